// File: rtl/gpu_issue_pkg.sv
// Shared issue-stage types for the warp scoreboard: sizes, id typedefs and
// the per-warp next-instruction operand bundle.
package gpu_issue_pkg;

  localparam int unsigned W       = 32;
  localparam int unsigned R       = 16;
  localparam int unsigned WID     = $clog2(W);
  localparam int unsigned RID     = $clog2(R);
  localparam int unsigned PCW     = $clog2(R + 1);
  localparam int unsigned NUM_SRC = 3;

  typedef logic [WID-1:0] warp_id_t;
  typedef logic [RID-1:0] reg_id_t;
  typedef logic [PCW-1:0] pcnt_t;

  // Operands of one warp's next instruction
  typedef struct packed {
    logic [NUM_SRC-1:0]    src_vld;
    reg_id_t [NUM_SRC-1:0] src_reg;
    logic                  dst_vld;
    reg_id_t               dst_reg;
  } warp_ops_t;

endpackage

// File: rtl/warp_scoreboard_ctrl_if.sv
// Scoreboard bus: dispatch, writeback and flush strobes, packed per-warp
// operand vectors, and the registered ready/idle/error results.
//   master : issue-side driver (buffers, arbiter, writeback bus)
//   slave  : warp_scoreboard_ctrl
interface warp_scoreboard_ctrl_if;
  import gpu_issue_pkg::*;

  logic                    disp_valid;
  warp_id_t                disp_warp_id;
  logic                    disp_dst_vld;
  reg_id_t                 disp_dst_reg;
  logic                    wb_valid;
  warp_id_t                wb_warp_id;
  reg_id_t                 wb_reg;
  logic                    flush_valid;
  warp_id_t                flush_warp_id;
  logic [NUM_SRC*W-1:0]    op_src_vld;
  logic [NUM_SRC*W*RID-1:0] op_src_reg;
  logic [W-1:0]            op_dst_vld;
  logic [W*RID-1:0]        op_dst_reg;
  logic [W-1:0]            scoreboard;
  logic [W-1:0]            warp_idle;
  logic                    sb_err;

  modport master (
    output disp_valid, disp_warp_id, disp_dst_vld, disp_dst_reg,
           wb_valid, wb_warp_id, wb_reg, flush_valid, flush_warp_id,
           op_src_vld, op_src_reg, op_dst_vld, op_dst_reg,
    input  scoreboard, warp_idle, sb_err
  );

  modport slave (
    input  disp_valid, disp_warp_id, disp_dst_vld, disp_dst_reg,
           wb_valid, wb_warp_id, wb_reg, flush_valid, flush_warp_id,
           op_src_vld, op_src_reg, op_dst_vld, op_dst_reg,
    output scoreboard, warp_idle, sb_err
  );

endinterface

// File: rtl/warp_scoreboard_ctrl_sb_warp_row.sv
// One warp's pending-write bitmap, pending counter and hazard check.
// Ports:
//   clk, rst          clock, async active-high reset
//   set_i/set_reg_i   dispatch writes set_reg_i (already decoded to this warp)
//   clr_i/clr_reg_i   writeback completes clr_reg_i
//   flush_i           drop all pending state of this warp
//   ops_i             next-instruction operands
//   ready_o           registered: no RAW/WAW hazard against next state
//   idle_o            registered: no pending writes in next state
//   err_c_o           combinational protocol-violation strobe
module sb_warp_row
  import gpu_issue_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_i,
  input  reg_id_t   set_reg_i,
  input  logic      clr_i,
  input  reg_id_t   clr_reg_i,
  input  logic      flush_i,
  input  warp_ops_t ops_i,
  output logic      ready_o,
  output logic      idle_o,
  output logic      err_c_o
);

  logic [R-1:0] pend_q, pend_d;
  pcnt_t        pcnt_q, pcnt_d;
  logic         ready_q, ready_d;
  logic         idle_q, idle_d;

  // Clears (writeback, flush) apply first, then the dispatch set
  always_comb begin
    pend_d  = pend_q;
    pcnt_d  = pcnt_q;
    err_c_o = 1'b0;

    if (clr_i && !pend_q[clr_reg_i]) err_c_o = 1'b1;

    if (flush_i) begin
      pend_d = '0;
      pcnt_d = '0;
    end else if (clr_i && pend_q[clr_reg_i]) begin
      pend_d[clr_reg_i] = 1'b0;
      if (pcnt_q == '0) err_c_o = 1'b1;
      else              pcnt_d  = pcnt_q - PCW'(1);
    end

    if (set_i) begin
      // Writeback racing a dispatch to the same register: set wins, flagged
      if (clr_i && (clr_reg_i == set_reg_i)) err_c_o = 1'b1;
      if (pend_d[set_reg_i]) begin
        err_c_o = 1'b1;
      end else begin
        pend_d[set_reg_i] = 1'b1;
        if (pcnt_d == PCW'(R)) err_c_o = 1'b1;
        else                   pcnt_d  = pcnt_d + PCW'(1);
      end
    end
  end

  // Hazard check uses next-state bitmap so no stale-ready cycle exists
  always_comb begin
    ready_d = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (ops_i.src_vld[s] && pend_d[ops_i.src_reg[s]]) ready_d = 1'b0;
    end
    if (ops_i.dst_vld && pend_d[ops_i.dst_reg]) ready_d = 1'b0;
    idle_d = (pcnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      pcnt_q  <= '0;
      ready_q <= 1'b1;
      idle_q  <= 1'b1;
    end else begin
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      ready_q <= ready_d;
      idle_q  <= idle_d;
    end
  end

  assign ready_o = ready_q;
  assign idle_o  = idle_q;

endmodule

// File: rtl/warp_scoreboard_ctrl.sv
// Per-warp register scoreboard feeding the issue arbiter.
// Ports:
//   clk    clock
//   rst    asynchronous reset, active-high
//   sb_if  slave side of warp_scoreboard_ctrl_if: dispatch/writeback/flush
//          strobes, per-warp operands in; scoreboard, warp_idle, sb_err out
module warp_scoreboard_ctrl
  import gpu_issue_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  warp_scoreboard_ctrl_if.slave        sb_if
);

  logic [W-1:0] set_s, clr_s, flush_s;
  logic [W-1:0] ready, idle, row_err;
  logic         id_err_c;
  logic         sb_err_q;

  // Decode warp ids into per-row strobes; out-of-range ids are dropped
  always_comb begin
    set_s    = '0;
    clr_s    = '0;
    flush_s  = '0;
    id_err_c = 1'b0;
    if (sb_if.disp_valid) begin
      if (32'(sb_if.disp_warp_id) >= W) id_err_c = 1'b1;
      else if (sb_if.disp_dst_vld)      set_s[sb_if.disp_warp_id] = 1'b1;
    end
    if (sb_if.wb_valid) begin
      if (32'(sb_if.wb_warp_id) >= W) id_err_c = 1'b1;
      else                            clr_s[sb_if.wb_warp_id] = 1'b1;
    end
    if (sb_if.flush_valid) begin
      if (32'(sb_if.flush_warp_id) >= W) id_err_c = 1'b1;
      else                               flush_s[sb_if.flush_warp_id] = 1'b1;
    end
  end

  for (genvar w = 0; w < W; w++) begin : g_row
    warp_ops_t ops;

    assign ops.src_vld = sb_if.op_src_vld[NUM_SRC*w +: NUM_SRC];
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign ops.src_reg[s] = sb_if.op_src_reg[(NUM_SRC*w + s)*RID +: RID];
    end
    assign ops.dst_vld = sb_if.op_dst_vld[w];
    assign ops.dst_reg = sb_if.op_dst_reg[w*RID +: RID];

    sb_warp_row u_row (
      .clk       (clk),
      .rst       (rst),
      .set_i     (set_s[w]),
      .set_reg_i (sb_if.disp_dst_reg),
      .clr_i     (clr_s[w]),
      .clr_reg_i (sb_if.wb_reg),
      .flush_i   (flush_s[w]),
      .ops_i     (ops),
      .ready_o   (ready[w]),
      .idle_o    (idle[w]),
      .err_c_o   (row_err[w])
    );
  end

  // Sticky protocol-violation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_q | id_err_c | (|row_err);
  end

  assign sb_if.scoreboard = ready;
  assign sb_if.warp_idle  = idle;
  assign sb_if.sb_err     = sb_err_q;

endmodule

// File: tb/tb_warp_scoreboard_ctrl.sv
// Directed bench for warp_scoreboard_ctrl with hand-computed expectations.
module tb_warp_scoreboard_ctrl;
  import gpu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  warp_scoreboard_ctrl_if sb_if ();

  warp_scoreboard_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .sb_if (sb_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_ops();
    sb_if.op_src_vld = '0;
    sb_if.op_src_reg = '0;
    sb_if.op_dst_vld = '0;
    sb_if.op_dst_reg = '0;
  endtask

  task automatic set_src(input int w, input int s, input int r);
    sb_if.op_src_vld[NUM_SRC*w + s]               = 1'b1;
    sb_if.op_src_reg[(NUM_SRC*w + s)*RID +: RID] = RID'(r);
  endtask

  task automatic set_dst(input int w, input int r);
    sb_if.op_dst_vld[w]             = 1'b1;
    sb_if.op_dst_reg[w*RID +: RID] = RID'(r);
  endtask

  task automatic disp(input int w, input int r);
    sb_if.disp_valid   = 1'b1;
    sb_if.disp_warp_id = WID'(w);
    sb_if.disp_dst_vld = 1'b1;
    sb_if.disp_dst_reg = RID'(r);
  endtask

  task automatic wb(input int w, input int r);
    sb_if.wb_valid   = 1'b1;
    sb_if.wb_warp_id = WID'(w);
    sb_if.wb_reg     = RID'(r);
  endtask

  task automatic flush(input int w);
    sb_if.flush_valid   = 1'b1;
    sb_if.flush_warp_id = WID'(w);
  endtask

  // One clock edge; sample point is 1 time unit after it, strobes drop
  task automatic step();
    @(posedge clk);
    #1;
    sb_if.disp_valid  = 1'b0;
    sb_if.disp_dst_vld = 1'b0;
    sb_if.wb_valid    = 1'b0;
    sb_if.flush_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    sb_if.disp_valid    = 1'b0;
    sb_if.disp_warp_id  = '0;
    sb_if.disp_dst_vld  = 1'b0;
    sb_if.disp_dst_reg  = '0;
    sb_if.wb_valid      = 1'b0;
    sb_if.wb_warp_id    = '0;
    sb_if.wb_reg        = '0;
    sb_if.flush_valid   = 1'b0;
    sb_if.flush_warp_id = '0;
    clr_ops();

    // 1: reset values
    do_reset();
    step();
    chk("t1_sb",   sb_if.scoreboard, 32'hFFFF_FFFF);
    chk("t1_idle", sb_if.warp_idle,  32'hFFFF_FFFF);
    chk("t1_err",  32'(sb_if.sb_err), 32'd0);

    // 2: RAW on w3 r5, cleared by writeback three cycles later
    set_src(3, 0, 5);
    disp(3, 5);
    step();
    chk("t2_sb_disp",   sb_if.scoreboard, 32'hFFFF_FFF7);
    chk("t2_idle_disp", sb_if.warp_idle,  32'hFFFF_FFF7);
    step();
    step();
    chk("t2_sb_hold", 32'(sb_if.scoreboard[3]), 32'd0);
    wb(3, 5);
    step();
    chk("t2_sb_wb",   sb_if.scoreboard, 32'hFFFF_FFFF);
    chk("t2_idle_wb", sb_if.warp_idle,  32'hFFFF_FFFF);

    // 3: WAW on w7 with three outstanding writes
    clr_ops();
    set_dst(7, 9);
    disp(7, 2);
    step();
    chk("t3_sb_r2",   32'(sb_if.scoreboard[7]), 32'd1);
    chk("t3_idle_r2", 32'(sb_if.warp_idle[7]),  32'd0);
    disp(7, 9);
    step();
    chk("t3_sb_r9", 32'(sb_if.scoreboard[7]), 32'd0);
    disp(7, 15);
    step();
    wb(7, 2);
    step();
    wb(7, 15);
    step();
    chk("t3_sb_one",   32'(sb_if.scoreboard[7]), 32'd0);
    chk("t3_idle_one", 32'(sb_if.warp_idle[7]),  32'd0);
    wb(7, 9);
    step();
    chk("t3_sb_done",   32'(sb_if.scoreboard[7]), 32'd1);
    chk("t3_idle_done", 32'(sb_if.warp_idle[7]),  32'd1);
    chk("t3_err",       32'(sb_if.sb_err), 32'd0);

    // 5: flush w0 with 4 pending, concurrent dispatch of r1
    clr_ops();
    disp(0, 0);  step();
    disp(0, 3);  step();
    disp(0, 7);  step();
    disp(0, 12); step();
    chk("t5_idle_four", 32'(sb_if.warp_idle[0]), 32'd0);
    set_src(0, 0, 1);
    flush(0);
    disp(0, 1);
    step();
    chk("t5_sb_r1",   32'(sb_if.scoreboard[0]), 32'd0);
    chk("t5_idle_r1", 32'(sb_if.warp_idle[0]),  32'd0);
    clr_ops();
    set_src(0, 0, 0);
    set_src(0, 1, 3);
    set_src(0, 2, 12);
    set_dst(0, 7);
    step();
    chk("t5_sb_flushed", 32'(sb_if.scoreboard[0]), 32'd1);
    wb(0, 1);
    step();
    chk("t5_idle_wb", 32'(sb_if.warp_idle[0]), 32'd1);
    chk("t5_err",     32'(sb_if.sb_err), 32'd0);

    // 4: dispatch and writeback of the same pending reg in one cycle
    clr_ops();
    set_src(1, 0, 4);
    disp(1, 4);
    step();
    chk("t4_sb_set",  32'(sb_if.scoreboard[1]), 32'd0);
    chk("t4_err_pre", 32'(sb_if.sb_err), 32'd0);
    disp(1, 4);
    wb(1, 4);
    step();
    chk("t4_err",  32'(sb_if.sb_err), 32'd1);
    chk("t4_sb",   32'(sb_if.scoreboard[1]), 32'd0);
    chk("t4_idle", 32'(sb_if.warp_idle[1]),  32'd0);
    wb(1, 4);
    step();
    chk("t4_idle_wb", 32'(sb_if.warp_idle[1]),  32'd1);
    chk("t4_sb_wb",   32'(sb_if.scoreboard[1]), 32'd1);
    step();
    chk("t4_err_sticky", 32'(sb_if.sb_err), 32'd1);

    // 6: spurious writeback, then reset with 10 pending
    clr_ops();
    do_reset();
    chk("t6_err_rst", 32'(sb_if.sb_err), 32'd0);
    wb(31, 0);
    step();
    chk("t6_err_spur",  32'(sb_if.sb_err), 32'd1);
    chk("t6_sb_spur",   sb_if.scoreboard, 32'hFFFF_FFFF);
    chk("t6_idle_spur", sb_if.warp_idle,  32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      disp(i + 2, i);
      step();
    end
    chk("t6_idle_ten", sb_if.warp_idle, 32'hFFFF_F003);
    set_src(2, 0, 0);
    set_src(11, 1, 9);
    step();
    chk("t6_sb_ten", sb_if.scoreboard, 32'hFFFF_F7FB);
    rst = 1'b1;
    #2;
    chk("t6_sb_async",   sb_if.scoreboard, 32'hFFFF_FFFF);
    chk("t6_idle_async", sb_if.warp_idle,  32'hFFFF_FFFF);
    chk("t6_err_async",  32'(sb_if.sb_err), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("t6_sb_post",   sb_if.scoreboard, 32'hFFFF_FFFF);
    chk("t6_idle_post", sb_if.warp_idle,  32'hFFFF_FFFF);
    wb(5, 3);
    step();
    chk("t6_err_late_wb", 32'(sb_if.sb_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
